// File: rtl/fnorm_arbiter_if.sv
// rtl/fnorm_arbiter_if.sv - requester, shared fnorm and result-buffer signal bundle
interface fnorm_arbiter_if #(
    parameter int NREQ = 3,
    parameter int FW1  = 26,
    parameter int FW2  = 23,
    parameter int EW1  = 10,
    parameter int EW2  = 8,
    parameter int TW   = 5,
    parameter int SW   = $clog2(NREQ)
);
    logic [NREQ-1:0]       req_valid_i;
    logic [NREQ-1:0]       req_ready_o;
    logic [NREQ*EW1-1:0]   req_exp_i;
    logic [NREQ*(FW1+1)-1:0] req_sig_i;
    logic [NREQ-1:0]       req_sign_i;
    logic [NREQ-1:0]       req_inf_i;
    logic [NREQ-1:0]       req_nan_i;
    logic [NREQ-1:0]       req_zero_i;
    logic [NREQ*3-1:0]     req_rm_i;
    logic [NREQ*TW-1:0]    req_tag_i;

    logic [2:0]            nrm_rm_o;
    logic [EW1-1:0]        nrm_exp_o;
    logic [FW1:0]          nrm_sig_o;
    logic                  nrm_sign_o;
    logic                  nrm_inf_o;
    logic                  nrm_nan_o;
    logic                  nrm_zero_o;

    logic [EW2-1:0]        nrm_exp_i;
    logic [FW2:0]          nrm_sig_i;
    logic                  nrm_sign_i;
    logic                  nrm_inf_i;
    logic                  nrm_nan_i;
    logic                  nrm_zero_i;

    logic                  res_valid_o;
    logic                  res_ready_i;
    logic [EW2-1:0]        res_exp_o;
    logic [FW2:0]          res_sig_o;
    logic                  res_sign_o;
    logic                  res_inf_o;
    logic                  res_nan_o;
    logic                  res_zero_o;
    logic [SW-1:0]         res_src_o;
    logic [TW-1:0]         res_tag_o;

    modport slave (
        input  req_valid_i, req_exp_i, req_sig_i, req_sign_i, req_inf_i,
               req_nan_i, req_zero_i, req_rm_i, req_tag_i,
               nrm_exp_i, nrm_sig_i, nrm_sign_i, nrm_inf_i, nrm_nan_i, nrm_zero_i,
               res_ready_i,
        output req_ready_o,
               nrm_rm_o, nrm_exp_o, nrm_sig_o, nrm_sign_o, nrm_inf_o, nrm_nan_o, nrm_zero_o,
               res_valid_o, res_exp_o, res_sig_o, res_sign_o, res_inf_o, res_nan_o,
               res_zero_o, res_src_o, res_tag_o
    );

    modport master (
        output req_valid_i, req_exp_i, req_sig_i, req_sign_i, req_inf_i,
               req_nan_i, req_zero_i, req_rm_i, req_tag_i,
               nrm_exp_i, nrm_sig_i, nrm_sign_i, nrm_inf_i, nrm_nan_i, nrm_zero_i,
               res_ready_i,
        input  req_ready_o,
               nrm_rm_o, nrm_exp_o, nrm_sig_o, nrm_sign_o, nrm_inf_o, nrm_nan_o, nrm_zero_o,
               res_valid_o, res_exp_o, res_sig_o, res_sign_o, res_inf_o, res_nan_o,
               res_zero_o, res_src_o, res_tag_o
    );
endinterface

// File: rtl/fnorm_arbiter.sv
// rtl/fnorm_arbiter.sv - round-robin sharing of one fnorm stage with a credited 2-entry result buffer
module fnorm_arbiter #(
    parameter int NREQ = 3,
    parameter int FW1  = 26,
    parameter int FW2  = 23,
    parameter int EW1  = 10,
    parameter int EW2  = 8,
    parameter int TW   = 5,
    parameter int SW   = $clog2(NREQ)
) (
    input  logic clk,
    input  logic rst,
    fnorm_arbiter_if.slave bus
);
    localparam int EN_W = SW + TW + EW2 + FW2 + 1 + 4;

    logic [SW-1:0]   rr_ptr;
    logic [SW-1:0]   grant;
    logic [SW:0]     scan;
    logic            found;
    logic            can_issue;
    logic            issue;
    logic            pop;
    logic            push;
    logic [2:0]      credit;

    logic            infl_q;
    logic [SW-1:0]   infl_src_q;
    logic [TW-1:0]   infl_tag_q;

    logic [EN_W-1:0] mem [2];
    logic [EN_W-1:0] push_entry;
    logic [EN_W-1:0] head_entry;
    logic            head_q;
    logic            tail_q;
    logic [1:0]      occ_q;

    // Scan from rr_ptr upward, wrapping modulo NREQ; first valid requester wins.
    always_comb begin
        found = 1'b0;
        grant = '0;
        scan  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, rr_ptr} + (SW+1)'(k);
            if (scan >= (SW+1)'(NREQ))
                scan = scan - (SW+1)'(NREQ);
            if (!found && bus.req_valid_i[scan[SW-1:0]]) begin
                found = 1'b1;
                grant = scan[SW-1:0];
            end
        end
    end

    assign bus.res_valid_o = (occ_q != 2'd0);
    assign pop       = bus.res_valid_o & bus.res_ready_i;
    assign push      = infl_q;
    // Pop term lets issue resume in the same cycle the consumer drains an entry.
    assign credit    = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
    assign can_issue = (credit < 3'd2);
    assign issue     = found & can_issue & ~rst;

    assign bus.req_ready_o = issue ? ({{(NREQ-1){1'b0}}, 1'b1} << grant) : '0;

    always_comb begin
        bus.nrm_rm_o   = '0;
        bus.nrm_exp_o  = '0;
        bus.nrm_sig_o  = '0;
        bus.nrm_sign_o = 1'b0;
        bus.nrm_inf_o  = 1'b0;
        bus.nrm_nan_o  = 1'b0;
        bus.nrm_zero_o = 1'b0;
        if (found) begin
            bus.nrm_rm_o   = bus.req_rm_i[grant*3 +: 3];
            bus.nrm_exp_o  = bus.req_exp_i[grant*EW1 +: EW1];
            bus.nrm_sig_o  = bus.req_sig_i[grant*(FW1+1) +: (FW1+1)];
            bus.nrm_sign_o = bus.req_sign_i[grant];
            bus.nrm_inf_o  = bus.req_inf_i[grant];
            bus.nrm_nan_o  = bus.req_nan_i[grant];
            bus.nrm_zero_o = bus.req_zero_i[grant];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            infl_q     <= 1'b0;
            infl_src_q <= '0;
            infl_tag_q <= '0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            infl_q <= issue;
            if (issue) begin
                infl_src_q <= grant;
                infl_tag_q <= bus.req_tag_i[grant*TW +: TW];
                rr_ptr     <= (grant == SW'(NREQ-1)) ? '0 : grant + SW'(1);
            end
            if (push)
                tail_q <= ~tail_q;
            if (pop)
                head_q <= ~head_q;
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign push_entry = {infl_src_q, infl_tag_q, bus.nrm_exp_i, bus.nrm_sig_i,
                         bus.nrm_sign_i, bus.nrm_inf_i, bus.nrm_nan_i, bus.nrm_zero_i};

    always_ff @(posedge clk) begin
        if (push)
            mem[tail_q] <= push_entry;
    end

    assign head_entry = bus.res_valid_o ? mem[head_q] : '0;
    assign {bus.res_src_o, bus.res_tag_o, bus.res_exp_o, bus.res_sig_o,
            bus.res_sign_o, bus.res_inf_o, bus.res_nan_o, bus.res_zero_o} = head_entry;

    buffer_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && occ_q == 2'd2));
endmodule
